// File: rtl/sysbus_arb_pkg.sv
// Shared types and constants for the Sysbus two-requester arbiter.
package sysbus_arb_pkg;

  localparam int BUS_DATA_W_DEF = 64;
  localparam int BUS_TAG_W_DEF  = 13;
  localparam int BEATS_PER_LINE = 8;
  localparam int BEAT_CNT_W     = $clog2(BEATS_PER_LINE);
  localparam int TAG_RW_BIT     = BUS_TAG_W_DEF - 1;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    WDATA,
    RESP
  } arb_state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } arb_owner_t;

  function automatic arb_owner_t other_owner(input arb_owner_t o);
    return (o == OWN_I) ? OWN_D : OWN_I;
  endfunction

endpackage

// File: rtl/sysbus_arbiter_if.sv
// One Sysbus port: request beats toward memory, response beats back.
interface sysbus_arbiter_if
  import sysbus_arb_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = BUS_DATA_W_DEF,
  parameter int BUS_TAG_WIDTH  = BUS_TAG_W_DEF
);
  logic                      reqcyc;
  logic [BUS_DATA_WIDTH-1:0] req;
  logic [BUS_TAG_WIDTH-1:0]  reqtag;
  logic                      respack;
  logic                      reqack;
  logic                      respcyc;
  logic [BUS_DATA_WIDTH-1:0] resp;
  logic [BUS_TAG_WIDTH-1:0]  resptag;

  modport master (
    output reqcyc, req, reqtag, respack,
    input  reqack, respcyc, resp, resptag
  );

  modport slave (
    input  reqcyc, req, reqtag, respack,
    output reqack, respcyc, resp, resptag
  );
endinterface

// File: rtl/sysbus_arbiter_rr_picker.sv
// Two-input round-robin pick; on a tie the side not granted last wins.
module rr_picker
  import sysbus_arb_pkg::*;
(
  input  logic       i_reqcyc,
  input  logic       d_reqcyc,
  input  arb_owner_t last_grant,
  output logic       grant_vld,
  output arb_owner_t grant
);

  always_comb begin
    grant_vld = i_reqcyc | d_reqcyc;
    grant     = OWN_I;
    if (i_reqcyc && d_reqcyc) begin
      grant = other_owner(last_grant);
    end else if (d_reqcyc) begin
      grant = OWN_D;
    end
  end

endmodule

// File: rtl/sysbus_arbiter.sv
// Shares the single Sysbus memory port between I-side and D-side caches,
// one full 64-byte line transaction at a time, round-robin between them.
module sysbus_arbiter
  import sysbus_arb_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = BUS_DATA_W_DEF,
  parameter int BUS_TAG_WIDTH  = BUS_TAG_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  sysbus_arbiter_if.slave    i_bus,
  sysbus_arbiter_if.slave    d_bus,
  sysbus_arbiter_if.master   m_bus
);

  localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(BEATS_PER_LINE - 1);
  localparam logic [BEAT_CNT_W-1:0] CNT_ONE   = BEAT_CNT_W'(1);

  arb_state_t                state;
  arb_owner_t                owner;
  arb_owner_t                last_grant;
  arb_owner_t                pick;
  logic                      pick_vld;
  logic [BEAT_CNT_W-1:0]     beat_cnt;

  logic                      own_reqcyc;
  logic                      own_respack;
  logic [BUS_DATA_WIDTH-1:0] own_req;
  logic [BUS_TAG_WIDTH-1:0]  own_reqtag;

  rr_picker u_picker (
    .i_reqcyc   (i_bus.reqcyc),
    .d_reqcyc   (d_bus.reqcyc),
    .last_grant (last_grant),
    .grant_vld  (pick_vld),
    .grant      (pick)
  );

  always_comb begin
    if (owner == OWN_I) begin
      own_reqcyc  = i_bus.reqcyc;
      own_req     = i_bus.req;
      own_reqtag  = i_bus.reqtag;
      own_respack = i_bus.respack;
    end else begin
      own_reqcyc  = d_bus.reqcyc;
      own_req     = d_bus.req;
      own_reqtag  = d_bus.reqtag;
      own_respack = d_bus.respack;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= OWN_I;
      last_grant <= OWN_D;
      beat_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            owner      <= pick;
            last_grant <= pick;
            state      <= ADDR;
          end
        end
        ADDR: begin
          // An owner that withdraws before the ack gives up its slot.
          if (!own_reqcyc) begin
            state <= IDLE;
          end else if (m_bus.reqack) begin
            beat_cnt <= '0;
            state    <= own_reqtag[BUS_TAG_WIDTH-1] ? RESP : WDATA;
          end
        end
        WDATA: begin
          if (m_bus.reqack) begin
            beat_cnt <= beat_cnt + CNT_ONE;
            if (beat_cnt == LAST_BEAT) state <= IDLE;
          end
        end
        RESP: begin
          if (m_bus.respcyc && own_respack) begin
            beat_cnt <= beat_cnt + CNT_ONE;
            if (beat_cnt == LAST_BEAT) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pass-through muxes; everything is forced low while reset is held.
  always_comb begin
    m_bus.reqcyc  = 1'b0;
    m_bus.req     = '0;
    m_bus.reqtag  = '0;
    m_bus.respack = 1'b0;
    i_bus.reqack  = 1'b0;
    i_bus.respcyc = 1'b0;
    i_bus.resp    = '0;
    i_bus.resptag = '0;
    d_bus.reqack  = 1'b0;
    d_bus.respcyc = 1'b0;
    d_bus.resp    = '0;
    d_bus.resptag = '0;
    if (reset) begin
      case (state)
        ADDR, WDATA: begin
          m_bus.reqcyc = own_reqcyc;
          m_bus.req    = own_req;
          m_bus.reqtag = own_reqtag;
          if (owner == OWN_I) i_bus.reqack = m_bus.reqack;
          else                d_bus.reqack = m_bus.reqack;
        end
        RESP: begin
          m_bus.respack = own_respack;
          if (owner == OWN_I) begin
            i_bus.respcyc = m_bus.respcyc;
            i_bus.resp    = m_bus.resp;
            i_bus.resptag = m_bus.resptag;
          end else begin
            d_bus.respcyc = m_bus.respcyc;
            d_bus.resp    = m_bus.resp;
            d_bus.resptag = m_bus.resptag;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Directed bench for sysbus_arbiter: per-cycle vector table plus corner sequences.
module tb_sysbus_arbiter;
  import sysbus_arb_pkg::*;

  localparam int DW = 64;
  localparam int TW = 13;
  localparam logic [TW-1:0] RD_TAG_I = TW'((1 << TAG_RW_BIT) | 'h011);
  localparam logic [TW-1:0] RD_TAG_D = TW'((1 << TAG_RW_BIT) | 'h022);
  localparam logic [TW-1:0] WR_TAG_D = TW'('h033);
  localparam logic [TW-1:0] RTAG     = TW'('h1ABC);

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  sysbus_arbiter_if #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW)) i_bus ();
  sysbus_arbiter_if #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW)) d_bus ();
  sysbus_arbiter_if #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW)) m_bus ();

  sysbus_arbiter #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW)) dut (
    .clk   (clk),
    .reset (reset),
    .i_bus (i_bus),
    .d_bus (d_bus),
    .m_bus (m_bus)
  );

  typedef struct {
    logic          i_reqcyc;
    logic [DW-1:0] i_req;
    logic [TW-1:0] i_reqtag;
    logic          i_respack;
    logic          d_reqcyc;
    logic [DW-1:0] d_req;
    logic [TW-1:0] d_reqtag;
    logic          d_respack;
    logic          m_reqack;
    logic          m_respcyc;
    logic [DW-1:0] m_resp;
    logic          e_m_reqcyc;
    logic [DW-1:0] e_m_req;
    logic [TW-1:0] e_m_reqtag;
    logic          e_m_respack;
    logic          e_i_reqack;
    logic          e_i_respcyc;
    logic [DW-1:0] e_i_resp;
    logic          e_d_reqack;
    logic          e_d_respcyc;
    logic [DW-1:0] e_d_resp;
  } vec_t;

  vec_t vt[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_bus.reqcyc = 0; i_bus.req = '0; i_bus.reqtag = '0; i_bus.respack = 0;
    d_bus.reqcyc = 0; d_bus.req = '0; d_bus.reqtag = '0; d_bus.respack = 0;
    m_bus.reqack = 0; m_bus.respcyc = 0; m_bus.resp = '0; m_bus.resptag = RTAG;
  endtask

  task automatic chk_zero(input string n);
    chk({n, " m_reqcyc"},  m_bus.reqcyc,  0);
    chk({n, " m_req"},     m_bus.req,     0);
    chk({n, " m_reqtag"},  m_bus.reqtag,  0);
    chk({n, " m_respack"}, m_bus.respack, 0);
    chk({n, " i_reqack"},  i_bus.reqack,  0);
    chk({n, " i_respcyc"}, i_bus.respcyc, 0);
    chk({n, " i_resp"},    i_bus.resp,    0);
    chk({n, " i_resptag"}, i_bus.resptag, 0);
    chk({n, " d_reqack"},  d_bus.reqack,  0);
    chk({n, " d_respcyc"}, d_bus.respcyc, 0);
    chk({n, " d_resp"},    d_bus.resp,    0);
    chk({n, " d_resptag"}, d_bus.resptag, 0);
  endtask

  // One acknowledged response beat to the given owner.
  task automatic beat(input bit to_i, input logic [DW-1:0] data, input string n);
    m_bus.respcyc = 1; m_bus.resp = data; i_bus.respack = 1; d_bus.respack = 1;
    #1;
    chk({n, " m_reqcyc"},  m_bus.reqcyc, 0);
    chk({n, " m_respack"}, m_bus.respack, 1);
    if (to_i) begin
      chk({n, " i_respcyc"}, i_bus.respcyc, 1);
      chk({n, " i_resp"},    i_bus.resp, data);
      chk({n, " d_respcyc"}, d_bus.respcyc, 0);
      chk({n, " d_resp"},    d_bus.resp, 0);
    end else begin
      chk({n, " d_respcyc"}, d_bus.respcyc, 1);
      chk({n, " d_resp"},    d_bus.resp, data);
      chk({n, " i_respcyc"}, i_bus.respcyc, 0);
      chk({n, " i_resp"},    i_bus.resp, 0);
    end
    tick();
  endtask

  task automatic do_reset();
    reset = 0;
    clear_inputs();
    tick();
    tick();
    reset = 1;
  endtask

  initial begin
    vec_t v;
    vec_t blank;
    blank = '{default: '0};

    // I read alone at 0x1000
    v = blank; v.i_reqcyc = 1; v.i_req = 64'h1000; v.i_reqtag = RD_TAG_I;
    vt.push_back(v);
    v.m_reqack = 1; v.e_m_reqcyc = 1; v.e_m_req = 64'h1000; v.e_m_reqtag = RD_TAG_I;
    v.e_i_reqack = 1;
    vt.push_back(v);
    for (int k = 0; k < 8; k++) begin
      v = blank; v.i_respack = 1; v.m_respcyc = 1; v.m_resp = 64'hA0 + 64'(k);
      v.e_m_respack = 1; v.e_i_respcyc = 1; v.e_i_resp = 64'hA0 + 64'(k);
      vt.push_back(v);
    end
    v = blank; v.i_respack = 1; v.m_respcyc = 1; v.m_resp = 64'hEE;
    vt.push_back(v);

    // D write at 0x2000, data 0x10..0x17
    v = blank; v.d_reqcyc = 1; v.d_req = 64'h2000; v.d_reqtag = WR_TAG_D;
    vt.push_back(v);
    v.m_reqack = 1; v.e_m_reqcyc = 1; v.e_m_req = 64'h2000; v.e_m_reqtag = WR_TAG_D;
    v.e_d_reqack = 1;
    vt.push_back(v);
    for (int k = 0; k < 8; k++) begin
      v = blank; v.d_reqcyc = 1; v.d_req = 64'h10 + 64'(k); v.d_reqtag = WR_TAG_D;
      v.m_reqack = 1; v.e_m_reqcyc = 1; v.e_m_req = 64'h10 + 64'(k);
      v.e_m_reqtag = WR_TAG_D; v.e_d_reqack = 1;
      vt.push_back(v);
    end
    v = blank; v.m_reqack = 1; v.m_respcyc = 1; v.d_respack = 1; v.m_resp = 64'hEE;
    vt.push_back(v);

    // Reset with busy-looking inputs: every output must read 0
    clear_inputs();
    i_bus.reqcyc = 1; d_bus.reqcyc = 1; m_bus.reqack = 1; m_bus.respcyc = 1;
    m_bus.resp = 64'hDEAD; i_bus.respack = 1; d_bus.respack = 1;
    tick();
    tick();
    chk_zero("reset");
    reset = 1;

    foreach (vt[k]) begin
      v = vt[k];
      i_bus.reqcyc = v.i_reqcyc; i_bus.req = v.i_req; i_bus.reqtag = v.i_reqtag;
      i_bus.respack = v.i_respack;
      d_bus.reqcyc = v.d_reqcyc; d_bus.req = v.d_req; d_bus.reqtag = v.d_reqtag;
      d_bus.respack = v.d_respack;
      m_bus.reqack = v.m_reqack; m_bus.respcyc = v.m_respcyc; m_bus.resp = v.m_resp;
      m_bus.resptag = RTAG;
      #1;
      chk($sformatf("v%0d m_reqcyc", k),  m_bus.reqcyc,  v.e_m_reqcyc);
      chk($sformatf("v%0d m_req", k),     m_bus.req,     v.e_m_req);
      chk($sformatf("v%0d m_reqtag", k),  m_bus.reqtag,  v.e_m_reqtag);
      chk($sformatf("v%0d m_respack", k), m_bus.respack, v.e_m_respack);
      chk($sformatf("v%0d i_reqack", k),  i_bus.reqack,  v.e_i_reqack);
      chk($sformatf("v%0d i_respcyc", k), i_bus.respcyc, v.e_i_respcyc);
      chk($sformatf("v%0d i_resp", k),    i_bus.resp,    v.e_i_resp);
      chk($sformatf("v%0d i_resptag", k), i_bus.resptag, v.e_i_respcyc ? RTAG : '0);
      chk($sformatf("v%0d d_reqack", k),  d_bus.reqack,  v.e_d_reqack);
      chk($sformatf("v%0d d_respcyc", k), d_bus.respcyc, v.e_d_respcyc);
      chk($sformatf("v%0d d_resp", k),    d_bus.resp,    v.e_d_resp);
      chk($sformatf("v%0d d_resptag", k), d_bus.resptag, v.e_d_respcyc ? RTAG : '0);
      tick();
    end

    // Tie after reset: I first, then D, then I again
    do_reset();
    i_bus.reqcyc = 1; i_bus.req = 64'h1000; i_bus.reqtag = RD_TAG_I;
    d_bus.reqcyc = 1; d_bus.req = 64'h3000; d_bus.reqtag = RD_TAG_D;
    #1; chk("tie1 idle m_reqcyc", m_bus.reqcyc, 0);
    tick();
    m_bus.reqack = 1;
    #1;
    chk("tie1 m_req", m_bus.req, 64'h1000);
    chk("tie1 i_reqack", i_bus.reqack, 1);
    chk("tie1 d_reqack", d_bus.reqack, 0);
    tick();
    m_bus.reqack = 0;
    for (int k = 0; k < 8; k++) beat(1, 64'hB0 + 64'(k), $sformatf("tie1 beat%0d", k));
    m_bus.respcyc = 0; i_bus.respack = 0; d_bus.respack = 0;
    #1; chk("tie2 idle m_reqcyc", m_bus.reqcyc, 0);
    tick();
    m_bus.reqack = 1;
    #1;
    chk("tie2 m_req", m_bus.req, 64'h3000);
    chk("tie2 m_reqtag", m_bus.reqtag, RD_TAG_D);
    chk("tie2 d_reqack", d_bus.reqack, 1);
    chk("tie2 i_reqack", i_bus.reqack, 0);
    tick();
    m_bus.reqack = 0;
    for (int k = 0; k < 8; k++) beat(0, 64'hC0 + 64'(k), $sformatf("tie2 beat%0d", k));
    m_bus.respcyc = 0; i_bus.respack = 0; d_bus.respack = 0;
    tick();
    #1;
    chk("tie3 m_req", m_bus.req, 64'h1000);
    chk("tie3 m_reqtag", m_bus.reqtag, RD_TAG_I);

    // Owner withdraws in ADDR: abort back to IDLE
    i_bus.reqcyc = 0; d_bus.reqcyc = 0;
    #1; chk("abort m_reqcyc", m_bus.reqcyc, 0);
    tick();
    i_bus.reqcyc = 1;
    #1; chk("abort idle m_reqcyc", m_bus.reqcyc, 0);
    tick();

    // Stalled read: respcyc gap after beat 3, owner holds off respack twice
    m_bus.reqack = 1;
    #1;
    chk("stall m_reqcyc", m_bus.reqcyc, 1);
    chk("stall i_reqack", i_bus.reqack, 1);
    tick();
    m_bus.reqack = 0; i_bus.reqcyc = 0;
    for (int k = 0; k < 3; k++) beat(1, 64'hA0 + 64'(k), $sformatf("stall beat%0d", k));
    m_bus.respcyc = 0; m_bus.resp = '0; i_bus.respack = 1; d_bus.respack = 0;
    #1;
    chk("stall gap i_respcyc", i_bus.respcyc, 0);
    chk("stall gap m_respack", m_bus.respack, 1);
    tick();
    for (int k = 0; k < 2; k++) begin
      m_bus.respcyc = 1; m_bus.resp = 64'hA3; i_bus.respack = 0; d_bus.respack = 1;
      #1;
      chk($sformatf("hold%0d i_respcyc", k), i_bus.respcyc, 1);
      chk($sformatf("hold%0d i_resp", k), i_bus.resp, 64'hA3);
      chk($sformatf("hold%0d m_respack", k), m_bus.respack, 0);
      tick();
    end
    for (int k = 3; k < 8; k++) beat(1, 64'hA0 + 64'(k), $sformatf("stall beat%0d", k));
    m_bus.resp = 64'hEE;
    #1;
    chk("stall end i_respcyc", i_bus.respcyc, 0);
    chk("stall end m_respack", m_bus.respack, 0);
    tick();

    // Reset during beat 5 of an I read
    clear_inputs();
    i_bus.reqcyc = 1; i_bus.req = 64'h1000; i_bus.reqtag = RD_TAG_I;
    tick();
    m_bus.reqack = 1;
    tick();
    m_bus.reqack = 0; i_bus.reqcyc = 0;
    for (int k = 0; k < 4; k++) beat(1, 64'hA0 + 64'(k), $sformatf("rst beat%0d", k));
    reset = 0;
    i_bus.reqcyc = 1; d_bus.reqcyc = 1; d_bus.req = 64'h3000; d_bus.reqtag = RD_TAG_D;
    m_bus.reqack = 1; m_bus.respcyc = 1; m_bus.resp = 64'hA4;
    #1; chk_zero("in reset");
    tick();
    reset = 1;
    #1; chk_zero("post reset");
    tick();
    m_bus.reqack = 0;
    #1;
    chk("post reset m_reqcyc", m_bus.reqcyc, 1);
    chk("post reset m_req", m_bus.req, 64'h1000);
    chk("post reset i_respcyc", i_bus.respcyc, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
